// File: rtl/irq_controller_if.sv
// Handshake bundle between the interrupt controller and the control unit:
// request/ack/finish plus the selected channel and its handler vector.
interface irq_controller_if #(
   parameter int NCH    = 4,
   parameter int ADDR_W = 10
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic              s_ack;
   logic              s_finished;
   logic              s_interruption;
   logic [ADDR_W-1:0] dir_from_exception;
   logic [CH_W-1:0]   active_ch;
   logic              in_service;

   // Interrupt controller side: raises the request and supplies the vector.
   modport master (
      input  s_ack,
      input  s_finished,
      output s_interruption,
      output dir_from_exception,
      output active_ch,
      output in_service
   );

   // Control unit side: acknowledges the jump and reports the return.
   modport slave (
      output s_ack,
      output s_finished,
      input  s_interruption,
      input  dir_from_exception,
      input  active_ch,
      input  in_service
   );
endinterface

// File: rtl/irq_controller.sv
// Vectored interrupt controller: rising-edge detection on NCH request lines,
// pending latch, software mask, fixed priority (channel 0 highest) and a
// request/ack/finish handshake with the control unit. No nesting.
module irq_controller #(
   parameter int                NCH        = 4,
   parameter int                ADDR_W     = 10,
   parameter int                DATA_W     = 8,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
   parameter int                VEC_STRIDE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    irq_in,
   input  logic              we_mask,
   input  logic [DATA_W-1:0] mask_in,
   output logic [NCH-1:0]    pending_out,
   irq_controller_if.master  cu
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NCH-1:0]    irq_prev_q;
   logic [NCH-1:0]    irq_edge;
   logic [NCH-1:0]    pending_q, pending_d;
   logic [NCH-1:0]    mask_q, mask_d;
   logic [NCH-1:0]    eligible;
   logic [NCH-1:0]    clr_vec;
   logic              clr_pend;
   logic [CH_W-1:0]   sel_ch;
   logic [CH_W-1:0]   active_ch_q, active_ch_d;
   logic [ADDR_W-1:0] vec_q, vec_d;

   // Mask bits above the channel count carry no meaning.
   generate
      if (NCH < DATA_W) begin : g_mask_hi
         logic unused_mask_hi;
         assign unused_mask_hi = ^mask_in[DATA_W-1:NCH];
      end
   endgenerate

   // Per-channel edge detect and pending update; a new edge beats a clear.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign irq_edge[gi]  = irq_in[gi] & ~irq_prev_q[gi];
         assign clr_vec[gi]   = clr_pend && (active_ch_q == CH_W'(gi));
         assign pending_d[gi] = irq_edge[gi] | (pending_q[gi] & ~clr_vec[gi]);
      end
   endgenerate

   assign eligible = pending_q & mask_q;

   // Previous sample of the request lines; also loaded during reset so a
   // line held high across reset does not look like a fresh edge.
   always_ff @(posedge clk) begin
      irq_prev_q <= irq_in;
   end

   // Fixed priority: lowest-index eligible channel wins.
   always_comb begin
      sel_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (eligible[i]) sel_ch = CH_W'(i);
      end
   end

   // Software mask register load.
   always_comb begin
      mask_d = mask_q;
      if (we_mask) mask_d = mask_in[NCH-1:0];
   end

   // Handshake FSM next state; channel and vector latch only when leaving IDLE.
   always_comb begin
      state_d     = state_q;
      active_ch_d = active_ch_q;
      vec_d       = vec_q;
      clr_pend    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d     = ST_REQ;
               active_ch_d = sel_ch;
               vec_d       = VEC_BASE + ADDR_W'(sel_ch) * ADDR_W'(VEC_STRIDE);
            end
         end
         ST_REQ: begin
            // Ack takes precedence over a mask write withdrawing the request.
            if (cu.s_ack) begin
               state_d  = ST_SERVICE;
               clr_pend = 1'b1;
            end else if (we_mask && !mask_in[active_ch_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (cu.s_finished) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, pending, mask and latched vector registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         mask_q      <= '0;
         active_ch_q <= '0;
         vec_q       <= VEC_BASE;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         active_ch_q <= active_ch_d;
         vec_q       <= vec_d;
      end
   end

   assign cu.s_interruption     = (state_q == ST_REQ);
   assign cu.in_service         = (state_q == ST_SERVICE);
   assign cu.dir_from_exception = vec_q;
   assign cu.active_ch          = active_ch_q;
   assign pending_out           = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, latency, priority, masking,
// frozen vector, request withdrawal, ack-vs-mask, set-wins and mid-service reset.
module tb_irq_controller;
   logic       clk;
   logic       reset;
   logic [3:0] irq_in;
   logic       we_mask;
   logic [7:0] mask_in;
   logic [3:0] pending_out;
   int         n_cmp;
   int         n_bad;

   irq_controller_if #(.NCH(4), .ADDR_W(10)) cu ();

   irq_controller #(
      .NCH(4), .ADDR_W(10), .DATA_W(8), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .irq_in(irq_in),
      .we_mask(we_mask),
      .mask_in(mask_in),
      .pending_out(pending_out),
      .cu(cu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack_and_finish();
      cu.s_ack = 1'b1; cyc(1); cu.s_ack = 1'b0;
      cu.s_finished = 1'b1; cyc(1); cu.s_finished = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; irq_in = 4'b0001;
      cyc(3);
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL rst_sint: got %b want 0", cu.s_interruption); end
      n_cmp++; if (cu.in_service !== 1'b0) begin n_bad++; $display("FAIL rst_insvc: got %b want 0", cu.in_service); end
      n_cmp++; if (pending_out !== 4'b0000) begin n_bad++; $display("FAIL rst_pend: got %b want 0000", pending_out); end
      n_cmp++; if (cu.dir_from_exception !== 10'h3C0) begin n_bad++; $display("FAIL rst_dir: got %h want 3c0", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd0) begin n_bad++; $display("FAIL rst_ch: got %0d want 0", cu.active_ch); end
      reset = 1'b1;
      cyc(3);
      n_cmp++; if (pending_out !== 4'b0000) begin n_bad++; $display("FAIL rst_held_pend: got %b want 0000", pending_out); end
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL rst_held_sint: got %b want 0", cu.s_interruption); end
      $display("test_reset done");
   endtask

   task automatic test_latency();
      we_mask = 1'b1; mask_in = 8'h0F; cyc(1); we_mask = 1'b0;
      irq_in = 4'b0101; cyc(1); irq_in = 4'b0001;
      n_cmp++; if (pending_out !== 4'b0100) begin n_bad++; $display("FAIL lat_pend: got %b want 0100", pending_out); end
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b want 0", cu.s_interruption); end
      cyc(1);
      n_cmp++; if (cu.s_interruption !== 1'b1) begin n_bad++; $display("FAIL lat_sint: got %b want 1", cu.s_interruption); end
      n_cmp++; if (cu.dir_from_exception !== 10'h3C8) begin n_bad++; $display("FAIL lat_dir: got %h want 3c8", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd2) begin n_bad++; $display("FAIL lat_ch: got %0d want 2", cu.active_ch); end
      cu.s_ack = 1'b1; cyc(1); cu.s_ack = 1'b0;
      n_cmp++; if (cu.in_service !== 1'b1) begin n_bad++; $display("FAIL lat_insvc: got %b want 1", cu.in_service); end
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL lat_sint_svc: got %b want 0", cu.s_interruption); end
      n_cmp++; if (pending_out !== 4'b0000) begin n_bad++; $display("FAIL lat_clr: got %b want 0000", pending_out); end
      cu.s_finished = 1'b1; cyc(1); cu.s_finished = 1'b0;
      irq_in = 4'b0000;
      n_cmp++; if (cu.in_service !== 1'b0) begin n_bad++; $display("FAIL lat_fin: got %b want 0", cu.in_service); end
      cyc(1);
      $display("test_latency done");
   endtask

   task automatic test_priority();
      irq_in = 4'b1010; cyc(1); irq_in = 4'b0000;
      n_cmp++; if (pending_out !== 4'b1010) begin n_bad++; $display("FAIL pri_pend: got %b want 1010", pending_out); end
      cyc(1);
      n_cmp++; if (cu.dir_from_exception !== 10'h3C4) begin n_bad++; $display("FAIL pri_dir1: got %h want 3c4", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd1) begin n_bad++; $display("FAIL pri_ch1: got %0d want 1", cu.active_ch); end
      cu.s_ack = 1'b1; cyc(1); cu.s_ack = 1'b0;
      n_cmp++; if (pending_out !== 4'b1000) begin n_bad++; $display("FAIL pri_left: got %b want 1000", pending_out); end
      cu.s_finished = 1'b1; cyc(1); cu.s_finished = 1'b0;
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL pri_idle: got %b want 0", cu.s_interruption); end
      cyc(1);
      n_cmp++; if (cu.s_interruption !== 1'b1) begin n_bad++; $display("FAIL pri_b2b: got %b want 1", cu.s_interruption); end
      n_cmp++; if (cu.dir_from_exception !== 10'h3CC) begin n_bad++; $display("FAIL pri_dir3: got %h want 3cc", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd3) begin n_bad++; $display("FAIL pri_ch3: got %0d want 3", cu.active_ch); end
      ack_and_finish();
      $display("test_priority done");
   endtask

   task automatic test_masked();
      // Upper mask bits are ignored, so this disables every channel.
      we_mask = 1'b1; mask_in = 8'hF0; cyc(1); we_mask = 1'b0;
      irq_in = 4'b0001; cyc(1); irq_in = 4'b0000;
      n_cmp++; if (pending_out !== 4'b0001) begin n_bad++; $display("FAIL msk_pend: got %b want 0001", pending_out); end
      cyc(2);
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL msk_noreq: got %b want 0", cu.s_interruption); end
      n_cmp++; if (pending_out !== 4'b0001) begin n_bad++; $display("FAIL msk_keep: got %b want 0001", pending_out); end
      we_mask = 1'b1; mask_in = 8'h01; cyc(1); we_mask = 1'b0;
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL msk_early: got %b want 0", cu.s_interruption); end
      cyc(1);
      n_cmp++; if (cu.s_interruption !== 1'b1) begin n_bad++; $display("FAIL msk_req: got %b want 1", cu.s_interruption); end
      n_cmp++; if (cu.dir_from_exception !== 10'h3C0) begin n_bad++; $display("FAIL msk_dir: got %h want 3c0", cu.dir_from_exception); end
      ack_and_finish();
      we_mask = 1'b1; mask_in = 8'h0F; cyc(1); we_mask = 1'b0;
      $display("test_masked done");
   endtask

   task automatic test_frozen();
      irq_in = 4'b0100; cyc(1); irq_in = 4'b0000;
      cyc(1);
      irq_in = 4'b0001; cyc(1); irq_in = 4'b0000;
      n_cmp++; if (cu.dir_from_exception !== 10'h3C8) begin n_bad++; $display("FAIL frz_dir: got %h want 3c8", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd2) begin n_bad++; $display("FAIL frz_ch: got %0d want 2", cu.active_ch); end
      n_cmp++; if (pending_out !== 4'b0101) begin n_bad++; $display("FAIL frz_pend: got %b want 0101", pending_out); end
      cu.s_ack = 1'b1; cyc(1); cu.s_ack = 1'b0;
      n_cmp++; if (pending_out !== 4'b0001) begin n_bad++; $display("FAIL frz_clr: got %b want 0001", pending_out); end
      cu.s_finished = 1'b1; cyc(1); cu.s_finished = 1'b0;
      cyc(1);
      n_cmp++; if (cu.dir_from_exception !== 10'h3C0) begin n_bad++; $display("FAIL frz_next: got %h want 3c0", cu.dir_from_exception); end
      n_cmp++; if (cu.s_interruption !== 1'b1) begin n_bad++; $display("FAIL frz_req: got %b want 1", cu.s_interruption); end
      ack_and_finish();
      $display("test_frozen done");
   endtask

   task automatic test_withdraw();
      irq_in = 4'b0010; cyc(1); irq_in = 4'b0000;
      cyc(1);
      n_cmp++; if (cu.active_ch !== 2'd1) begin n_bad++; $display("FAIL wd_ch: got %0d want 1", cu.active_ch); end
      we_mask = 1'b1; mask_in = 8'h0D; cyc(1); we_mask = 1'b0;
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL wd_drop: got %b want 0", cu.s_interruption); end
      n_cmp++; if (pending_out !== 4'b0010) begin n_bad++; $display("FAIL wd_pend: got %b want 0010", pending_out); end
      // Stray ack outside REQ must be ignored.
      cu.s_ack = 1'b1; cyc(1); cu.s_ack = 1'b0;
      n_cmp++; if (cu.in_service !== 1'b0) begin n_bad++; $display("FAIL wd_stray_ack: got %b want 0", cu.in_service); end
      n_cmp++; if (pending_out !== 4'b0010) begin n_bad++; $display("FAIL wd_stray_pend: got %b want 0010", pending_out); end
      we_mask = 1'b1; mask_in = 8'h0F; cyc(1); we_mask = 1'b0;
      cyc(1);
      n_cmp++; if (cu.s_interruption !== 1'b1) begin n_bad++; $display("FAIL wd_rereq: got %b want 1", cu.s_interruption); end
      // Ack and disabling mask write together: ack wins.
      cu.s_ack = 1'b1; we_mask = 1'b1; mask_in = 8'h0D; cyc(1);
      cu.s_ack = 1'b0; we_mask = 1'b0;
      n_cmp++; if (cu.in_service !== 1'b1) begin n_bad++; $display("FAIL wd_ackwins: got %b want 1", cu.in_service); end
      n_cmp++; if (pending_out !== 4'b0000) begin n_bad++; $display("FAIL wd_ackclr: got %b want 0000", pending_out); end
      cu.s_finished = 1'b1; cyc(1); cu.s_finished = 1'b0;
      we_mask = 1'b1; mask_in = 8'h0F; cyc(1); we_mask = 1'b0;
      $display("test_withdraw done");
   endtask

   task automatic test_setwins_reset();
      irq_in = 4'b0100; cyc(1); irq_in = 4'b0000;
      cyc(1);
      n_cmp++; if (cu.active_ch !== 2'd2) begin n_bad++; $display("FAIL sw_ch: got %0d want 2", cu.active_ch); end
      irq_in = 4'b0100; cu.s_ack = 1'b1; cyc(1);
      irq_in = 4'b0000; cu.s_ack = 1'b0;
      n_cmp++; if (cu.in_service !== 1'b1) begin n_bad++; $display("FAIL sw_insvc: got %b want 1", cu.in_service); end
      n_cmp++; if (pending_out !== 4'b0100) begin n_bad++; $display("FAIL sw_pend: got %b want 0100", pending_out); end
      reset = 1'b0; cyc(1);
      n_cmp++; if (cu.in_service !== 1'b0) begin n_bad++; $display("FAIL mr_insvc: got %b want 0", cu.in_service); end
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL mr_sint: got %b want 0", cu.s_interruption); end
      n_cmp++; if (pending_out !== 4'b0000) begin n_bad++; $display("FAIL mr_pend: got %b want 0000", pending_out); end
      n_cmp++; if (cu.dir_from_exception !== 10'h3C0) begin n_bad++; $display("FAIL mr_dir: got %h want 3c0", cu.dir_from_exception); end
      n_cmp++; if (cu.active_ch !== 2'd0) begin n_bad++; $display("FAIL mr_ch: got %0d want 0", cu.active_ch); end
      reset = 1'b1; cyc(1);
      // Mask was cleared by reset: a new edge only becomes pending.
      irq_in = 4'b0001; cyc(1); irq_in = 4'b0000;
      cyc(2);
      n_cmp++; if (pending_out !== 4'b0001) begin n_bad++; $display("FAIL mr_newpend: got %b want 0001", pending_out); end
      n_cmp++; if (cu.s_interruption !== 1'b0) begin n_bad++; $display("FAIL mr_maskclr: got %b want 0", cu.s_interruption); end
      $display("test_setwins_reset done");
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      reset = 1'b0; irq_in = 4'b0000; we_mask = 1'b0; mask_in = 8'h00;
      cu.s_ack = 1'b0; cu.s_finished = 1'b0;
      test_reset();
      test_latency();
      test_priority();
      test_masked();
      test_frozen();
      test_withdraw();
      test_setwins_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
